// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: drives one full-subtractor cell LSB first.
// Optional signed-overflow output enabled by defining SERSUB_OVF_EN.
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             zero
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic            brw;
    logic [CW-1:0]   cnt;
    logic            cell_d;
    logic            cell_bo;
    logic            last_c;

`ifdef SERSUB_OVF_EN
    logic            a_msb;
    logic            b_msb;
`endif

    assign last_c = (cnt == CW'(WIDTH - 1));

    full_subtractor u_cell (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (brw),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow chain and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
`ifdef SERSUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        brw   <= 1'b0;
                        cnt   <= '0;
`ifdef SERSUB_OVF_EN
                        a_msb <= a_in[WIDTH-1];
                        b_msb <= b_in[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    r_sr <= {cell_d, r_sr[WIDTH-1:1]};
                    brw  <= cell_bo;
                    cnt  <= cnt + CW'(1);
                end
                DONE: begin
                    result <= r_sr;
                    bout   <= brw;
                    zero   <= (r_sr == '0);
                    done   <= 1'b1;
`ifdef SERSUB_OVF_EN
                    // Signed overflow: operands differ in sign and result sign departs from minuend
                    ovf    <= (a_msb != b_msb) && (r_sr[WIDTH-1] != a_msb);
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// One-bit full subtractor built from two half-subtractor stages.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .x (x),
        .y (y),
        .d (d1),
        .b (b1)
    );

    half_subtractor u_hs1 (
        .x (d1),
        .y (bin),
        .d (d),
        .b (b2)
    );

    assign bo = b1 | b2;

endmodule

// One-bit half subtractor: d = x - y, b = borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);

    assign d = x ^ y;
    assign b = ~x & y;

endmodule
